// File: rtl/aud_dac_out_pkg.sv
// Shared types and helpers for the audio DAC back-end.
package aud_dac_out_pkg;

   localparam int PCM_W = 6;

   typedef enum logic {
      MODE_SD  = 1'b0,
      MODE_PWM = 1'b1
   } mode_e;

   function automatic logic [PCM_W-1:0] chan_sum(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic [3:0] c,
                                                 input logic [3:0] d);
      return PCM_W'(a) + PCM_W'(b) + PCM_W'(c) + PCM_W'(d);
   endfunction

endpackage

// File: rtl/aud_dac_out_sd_mod.sv
// First-order sigma-delta accumulator; carry is the one-bit output before registering.
module aud_sd_mod
   import aud_dac_out_pkg::*;
#(
   parameter int ACC_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PCM_W-1:0] pcm,
   input  logic             clear,
   output logic             carry
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;

   assign sum   = {1'b0, acc} + (ACC_W+1)'(pcm);
   assign carry = sum[ACC_W];

   always_ff @(negedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else begin
         acc <= sum[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/aud_dac_out.sv
// Four-channel volume summer driving a one-bit DAC pin via sigma-delta or PWM.
// state    | meaning
// MODE_SD  | sigma-delta carry drives the pin, PWM counter parked at 0
// MODE_PWM | counter compare drives the pin, duty reloads only at period wrap
module aud_dac_out
   import aud_dac_out_pkg::*;
#(
   parameter int PWM_TOP = 63,
   parameter int ACC_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enn,
   input  logic [3:0]       AUD1,
   input  logic [3:0]       AUD2,
   input  logic [3:0]       AUD3,
   input  logic [3:0]       AUD4,
   input  logic             pwmSel,
   input  logic             mute,
   output logic [PCM_W-1:0] pcm,
   output logic             sampleStb,
   output logic             audOut
);

   localparam int CNT_W = $clog2(PWM_TOP + 1);

   mode_e            mode_q, mode_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [PCM_W-1:0] pwm_duty, duty_nxt;
   logic             aud_nxt;
   logic             mode_chg;
   logic             at_top;
   logic             sd_carry;

   assign mode_chg = (pwmSel != mode_q);
   assign at_top   = (cnt == CNT_W'(PWM_TOP));

   aud_sd_mod #(.ACC_W(ACC_W)) u_sd (
      .clk   (clk),
      .rst   (rst),
      .pcm   (pcm),
      .clear (mode_chg || (mode_q == MODE_PWM)),
      .carry (sd_carry)
   );

   always_ff @(negedge clk) begin
      if (rst) begin
         pcm       <= '0;
         sampleStb <= 1'b0;
      end else begin
         sampleStb <= enn;
         if (enn) begin
            pcm <= mute ? '0 : chan_sum(AUD1, AUD2, AUD3, AUD4);
         end
      end
   end

   always_comb begin
      mode_nxt = mode_e'(pwmSel);
      cnt_nxt  = cnt;
      duty_nxt = pwm_duty;
      aud_nxt  = audOut;
      if (mode_chg) begin
         cnt_nxt  = '0;
         duty_nxt = pcm;
         aud_nxt  = 1'b0;
      end else if (mode_q == MODE_PWM) begin
         cnt_nxt = at_top ? '0 : cnt + 1'b1;
         // duty uses the registered pcm, so a coincident enn lands one period later
         if (at_top) begin
            duty_nxt = pcm;
         end
         aud_nxt = (32'(cnt) < 32'(pwm_duty));
      end else begin
         cnt_nxt = '0;
         aud_nxt = sd_carry;
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         mode_q   <= MODE_SD;
         cnt      <= '0;
         pwm_duty <= '0;
         audOut   <= 1'b0;
      end else begin
         mode_q   <= mode_nxt;
         cnt      <= cnt_nxt;
         pwm_duty <= duty_nxt;
         audOut   <= aud_nxt;
      end
   end

endmodule

// File: tb/tb_aud_dac_out.sv
// Directed bench for aud_dac_out; DUT updates on negedge, bench drives and samples on posedge.
module tb_aud_dac_out;

   logic       clk = 1'b0;
   logic       rst;
   logic       enn;
   logic [3:0] aud1, aud2, aud3, aud4;
   logic       pwm_sel;
   logic       mute;
   logic [5:0] pcm;
   logic       sample_stb;
   logic       aud_out;

   int n_checks = 0;
   int n_fail   = 0;
   int ones;
   int hi [5];
   int hi_exp [5] = '{8, 8, 40, 40, 36};

   always #5 clk = ~clk;

   aud_dac_out #(.PWM_TOP(63), .ACC_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .enn       (enn),
      .AUD1      (aud1),
      .AUD2      (aud2),
      .AUD3      (aud3),
      .AUD4      (aud4),
      .pwmSel    (pwm_sel),
      .mute      (mute),
      .pcm       (pcm),
      .sampleStb (sample_stb),
      .audOut    (aud_out)
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; enn = 1'b0; pwm_sel = 1'b0; mute = 1'b0;
      aud1 = 4'hF; aud2 = 4'hF; aud3 = 4'hF; aud4 = 4'hF;
      @(posedge clk);

      // reset held with enn toggling and full-scale inputs
      for (int i = 0; i < 3; i++) begin
         enn = (i % 2 == 0);
         @(posedge clk);
         check_eq("rst_pcm", pcm, 0);
         check_eq("rst_stb", sample_stb, 0);
         check_eq("rst_aud", aud_out, 0);
      end
      rst = 1'b0; enn = 1'b0;
      @(posedge clk);
      check_eq("rel_pcm", pcm, 0);
      check_eq("rel_stb", sample_stb, 0);
      check_eq("rel_aud", aud_out, 0);

      // sigma-delta full scale
      enn = 1'b1;
      @(posedge clk);
      check_eq("sd_pcm60", pcm, 60);
      check_eq("sd_stb_hi", sample_stb, 1);
      enn = 1'b0;
      @(posedge clk);
      check_eq("sd_stb_lo", sample_stb, 0);
      repeat (4) @(posedge clk);
      ones = 0;
      repeat (64) begin
         @(posedge clk);
         ones += int'(aud_out);
      end
      check_eq("sd_ones60", ones, 60);

      // zero input gives silence
      aud1 = 0; aud2 = 0; aud3 = 0; aud4 = 0; enn = 1'b1;
      @(posedge clk);
      check_eq("sd_pcm0", pcm, 0);
      enn = 1'b0;
      @(posedge clk);
      ones = 0;
      repeat (20) begin
         @(posedge clk);
         ones += int'(aud_out);
      end
      check_eq("sd_ones0", ones, 0);

      // mute and strobe width
      aud1 = 4'hF; aud2 = 4'hF; aud3 = 4'hF; aud4 = 4'hF; mute = 1'b1; enn = 1'b1;
      @(posedge clk);
      check_eq("mute_pcm", pcm, 0);
      check_eq("mute_stb_hi", sample_stb, 1);
      enn = 1'b0;
      @(posedge clk);
      check_eq("mute_stb_lo", sample_stb, 0);
      mute = 1'b0; enn = 1'b1;
      @(posedge clk);
      check_eq("unmute_pcm", pcm, 60);
      enn = 1'b0;
      @(posedge clk);

      // PWM with sum 8, then mid-period and wrap-coincident updates
      aud1 = 4'd5; aud2 = 4'd3; aud3 = 0; aud4 = 0; enn = 1'b1;
      @(posedge clk);
      check_eq("pwm_pcm8", pcm, 8);
      enn = 1'b0;
      pwm_sel = 1'b1;
      foreach (hi[p]) hi[p] = 0;
      for (int j = 1; j <= 354; j++) begin
         @(posedge clk);
         if (j >= 2 && j <= 321) hi[(j - 2) / 64] += int'(aud_out);
         if (j == 66)  check_eq("pwm_cnt0_hi", aud_out, 1);
         if (j == 73)  check_eq("pwm_cnt7_hi", aud_out, 1);
         if (j == 74)  check_eq("pwm_cnt8_lo", aud_out, 0);
         if (j == 86)  check_eq("pwm_pcm40", pcm, 40);
         if (j == 193) check_eq("pwm_pcm36", pcm, 36);
         if (j == 351) check_eq("pwm_pre_sw", aud_out, 1);
         if (j == 352) check_eq("sw_aud0", aud_out, 0);
         if (j == 353) check_eq("sw_sd_first", aud_out, 0);
         if (j == 354) check_eq("sw_sd_second", aud_out, 1);
         enn = (j == 85 || j == 192);
         if (j == 85)  begin aud1 = 15; aud2 = 15; aud3 = 10; aud4 = 0; end
         if (j == 192) begin aud1 = 15; aud2 = 15; aud3 = 6;  aud4 = 0; end
         if (j == 351) pwm_sel = 1'b0;
      end
      foreach (hi[p]) check_eq($sformatf("pwm_period%0d_high", p), hi[p], hi_exp[p]);

      // back to PWM, reset at cnt=10
      pwm_sel = 1'b1;
      for (int m = 1; m <= 14; m++) begin
         @(posedge clk);
         if (m == 11) check_eq("pre_rst_aud", aud_out, 1);
         if (m == 12) begin
            check_eq("midrst_pcm", pcm, 0);
            check_eq("midrst_aud", aud_out, 0);
            check_eq("midrst_stb", sample_stb, 0);
         end
         if (m == 13) check_eq("postrst_aud1", aud_out, 0);
         if (m == 14) check_eq("postrst_aud2", aud_out, 0);
         rst = (m == 11);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
